dmem_port_sched: RTL and testbench
==================================

// Module: dmem_port_sched
// PURPOSE
//  Schedules the single-port 32-byte data memory between two requesters: store commit (writes) and the
//  load unit (reads). Round-robin arbitration on valid/ready handshakes; at most one memory op per cycle.
//  mem_write and mem_read are never asserted together, by construction. Returns load data with its tag.
//  Sits between the LSU/ROB commit path and the data memory.
// PARAMETERS
//  ADDR_W    32  request/memory address width; memory decodes addr[4:0], wraps mod 32
//  DATA_W    32  store/load data width (4 bytes, little-endian in memory)
//  TAG_W     4   load tag width, returned unchanged with the response
// PORTS
//  clk            in   1       clock
//  reset_n        in   1       asynchronous active-low reset
//  flush          in   1       squash all loads that have not yet completed; stores are unaffected
//  st_valid       in   1       store request valid
//  st_ready       out  1       store accepted this cycle
//  st_addr        in   ADDR_W  store byte address
//  st_data        in   DATA_W  store data
//  ld_valid       in   1       load request valid
//  ld_ready       out  1       load accepted this cycle
//  ld_addr        in   ADDR_W  load byte address
//  ld_tag         in   TAG_W   load tag
//  ld_resp_valid  out  1       load response valid (registered)
//  ld_resp_ready  in   1       consumer accepts the response
//  ld_resp_tag    out  TAG_W   tag of the returned load
//  ld_resp_data   out  DATA_W  loaded word
//  mem_addr       out  ADDR_W  to memory addr
//  mem_wr_data    out  DATA_W  to memory wr_data
//  mem_write      out  1       to memory MemWrite
//  mem_read       out  1       to memory MemRead
//  mem_rd_data    in   DATA_W  from memory rd_data (updates on the edge that samples mem_read)
//  busy           out  1       any entry valid in the issue, read-wait or response stages
// BEHAVIOUR
//  Reset (async assert): all valids 0, rr pointer = STORE first, every output 0. Memory contents are not cleared here.
//  Pipeline: accept at edge E0 -> issue reg drives mem_* in cycle N+1 -> memory samples at E1 ->
//   rd_wait stage (E1..E2) -> response reg loaded from mem_rd_data at E2 -> ld_resp_valid in N+3.
//   Load latency from accept to ld_resp_valid = 3 cycles. Stores finish at E1 and have no response.
//  mem_write = iss_v & iss_kind==WR; mem_read = iss_v & iss_kind==RD; mem_addr/mem_wr_data come from the
//   issue reg. When the issue reg is empty, they hold their last values.
//  Issue reg is free every cycle, so the scheduler can accept one request per cycle (stores back-to-back).
//  Load eligibility: ld_ready only when no load is outstanding (issue RD, rd_wait, or resp reg all empty;
//   resp reg counts as free when it is being popped this cycle) and flush==0.
//  Arbitration: if only one side is valid and eligible, that side is granted. If both are, the rr pointer
//   picks the side, then the pointer moves to the other side. A single-side grant also moves the pointer.
//  ready depends combinationally on valid; requesters must not make valid depend on ready.
//  Requests reach memory in acceptance order, so a load accepted after a store to the same address sees the new data.
//  Response: ld_resp_valid/tag/data hold stable until ld_resp_ready=1. A pop and a newly arriving
//   response cannot occur in the same cycle (single outstanding load).
//  Flush: at the edge where flush=1, clear the RD issue entry, rd_wait and the resp reg. ld_resp_valid=0 from the next cycle.
//   A RD already driven on mem_read in the flush cycle still reads memory, but its data is discarded.
//   A WR issue entry completes normally. A store can still be accepted during flush.
//  Out-of-range addresses are not flagged: bits above [4:0] are passed through and ignored by memory.
//  Word writes at addr[4:0] > 28 wrap within the memory. This is legal.
//  Assertion: !(mem_write && mem_read) whenever reset_n==1.
// STRUCTURE
//  Package dmem_sched_pkg: req_kind_e {RD, WR}; issue_t struct {kind, addr, data, tag}; MEM_BYTES=32.
//  Sub-module rr_arb2: 2-way round-robin arbiter (req[1:0], grant[1:0], pointer register).
//  Top level: issue reg, rd_wait valid+tag, resp reg, flush/kill logic.
// TESTING
//  1. Reset mid-operation: load in rd_wait, assert reset_n=0 -> all outputs 0 at once; after release, no stale response.
//  2. Store 0xDEADBEEF @0x04, then load @0x04 tag 3 next cycle -> ld_resp_valid 3 cycles after load accept, data 0xDEADBEEF, tag 3.
//  3. st_valid and ld_valid held high together for 4 cycles from reset -> grants ST,LD,ST(ld blocked, outstanding),...; never mem_write&&mem_read.
//  4. Load tag 5 accepted, ld_resp_ready=0 for 5 cycles -> resp stays valid with tag 5 and stable data, ld_ready=0 until popped.
//  5. Load tag 7 accepted, flush one cycle later -> no response for tag 7; ld_ready=1 the cycle after flush.
//  6. Store 0x11223344 @0x1E -> bytes 0x44,0x33 at 0x1E,0x1F and 0x22,0x11 at 0x00,0x01; load @0x1E returns 0x11223344.

Source files
------------

// File: rtl/dmem_port_sched_pkg.sv
// rtl/dmem_port_sched_pkg.sv - shared types for the data memory port scheduler
package dmem_sched_pkg;

  localparam int ADDR_W_P  = 32;
  localparam int DATA_W_P  = 32;
  localparam int TAG_W_P   = 4;
  localparam int MEM_BYTES = 32;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } req_kind_e;

  typedef struct packed {
    req_kind_e             kind;
    logic [ADDR_W_P-1:0]   addr;
    logic [DATA_W_P-1:0]   data;
    logic [TAG_W_P-1:0]    tag;
  } issue_t;

endpackage

// File: rtl/dmem_port_sched_rr_arb2.sv
// rtl/dmem_port_sched_rr_arb2.sv - two-way round-robin arbiter, bit 0 preferred after reset
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant
);

  logic r_ptr;

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_ptr ? 2'b10 : 2'b01;
      default: o_grant = 2'b00;
    endcase
  end

  // Any grant hands priority to the other side, single-sided grants included.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ptr <= 1'b0;
    end else if (o_grant[0]) begin
      r_ptr <= 1'b1;
    end else if (o_grant[1]) begin
      r_ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_port_sched.sv
// rtl/dmem_port_sched.sv - schedules store commits and loads onto one data memory port
module dmem_port_sched
  import dmem_sched_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_P,
  parameter int DATA_W = DATA_W_P,
  parameter int TAG_W  = TAG_W_P
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_flush,
  input  logic              i_st_valid,
  output logic              o_st_ready,
  input  logic [ADDR_W-1:0] i_st_addr,
  input  logic [DATA_W-1:0] i_st_data,
  input  logic              i_ld_valid,
  output logic              o_ld_ready,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [TAG_W-1:0]  i_ld_tag,
  output logic              o_ld_resp_valid,
  input  logic              i_ld_resp_ready,
  output logic [TAG_W-1:0]  o_ld_resp_tag,
  output logic [DATA_W-1:0] o_ld_resp_data,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wr_data,
  output logic              o_mem_write,
  output logic              o_mem_read,
  input  logic [DATA_W-1:0] i_mem_rd_data,
  output logic              o_busy
);

  issue_t             r_iss;
  logic               r_iss_v;
  logic               r_rw_v;
  logic [TAG_W-1:0]   r_rw_tag;
  logic               r_resp_v;
  logic [TAG_W-1:0]   r_resp_tag;
  logic [DATA_W-1:0]  r_resp_data;

  logic               w_iss_rd;
  logic               w_iss_wr;
  logic               w_resp_hold;
  logic               w_ld_elig;
  logic [1:0]         w_req;
  logic [1:0]         w_grant;

  assign w_iss_rd    = r_iss_v && (r_iss.kind == RD);
  assign w_iss_wr    = r_iss_v && (r_iss.kind == WR);
  assign w_resp_hold = r_resp_v && !i_ld_resp_ready;

  // Only one load in flight; a response being popped this cycle frees the slot.
  assign w_ld_elig = !(w_iss_rd || r_rw_v || w_resp_hold) && !i_flush;
  assign w_req     = {i_ld_valid && w_ld_elig, i_st_valid} & {2{i_reset_n}};

  rr_arb2 u_arb (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_req     (w_req),
    .o_grant   (w_grant)
  );

  assign o_st_ready = w_grant[0];
  assign o_ld_ready = w_grant[1];

  // Payload fields are only rewritten on a grant so mem_addr/mem_wr_data hold when idle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_iss_v <= 1'b0;
      r_iss   <= '0;
    end else begin
      r_iss_v <= |w_grant;
      if (w_grant[0]) begin
        r_iss.kind <= WR;
        r_iss.addr <= i_st_addr;
        r_iss.data <= i_st_data;
      end else if (w_grant[1]) begin
        r_iss.kind <= RD;
        r_iss.addr <= i_ld_addr;
        r_iss.tag  <= i_ld_tag;
      end
    end
  end

  // A read already on the port during flush still hits memory; dropping it here discards the data.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rw_v   <= 1'b0;
      r_rw_tag <= '0;
    end else begin
      r_rw_v <= w_iss_rd && !i_flush;
      if (w_iss_rd) begin
        r_rw_tag <= r_iss.tag;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_resp_v    <= 1'b0;
      r_resp_tag  <= '0;
      r_resp_data <= '0;
    end else if (i_flush) begin
      r_resp_v <= 1'b0;
    end else if (r_rw_v) begin
      r_resp_v    <= 1'b1;
      r_resp_tag  <= r_rw_tag;
      r_resp_data <= i_mem_rd_data;
    end else if (i_ld_resp_ready) begin
      r_resp_v <= 1'b0;
    end
  end

  assign o_mem_write     = w_iss_wr;
  assign o_mem_read      = w_iss_rd;
  assign o_mem_addr      = r_iss.addr;
  assign o_mem_wr_data   = r_iss.data;
  assign o_ld_resp_valid = r_resp_v;
  assign o_ld_resp_tag   = r_resp_tag;
  assign o_ld_resp_data  = r_resp_data;
  assign o_busy          = r_iss_v || r_rw_v || r_resp_v;

  a_rw_exclusive: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !(o_mem_write && o_mem_read));

endmodule

// File: tb/tb_dmem_port_sched.sv
// tb/tb_dmem_port_sched.sv - directed-vector bench with a byte-wide 32-entry memory model
module tb_dmem_port_sched;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        st_valid, st_ready;
  logic [31:0] st_addr, st_data;
  logic        ld_valid, ld_ready;
  logic [31:0] ld_addr;
  logic [3:0]  ld_tag;
  logic        resp_valid, resp_ready;
  logic [3:0]  resp_tag;
  logic [31:0] resp_data;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
  logic        mem_write, mem_read;
  logic        busy;

  logic [7:0]  mem [32];
  logic [4:0]  ma;

  int n_vec = 0;
  int n_err = 0;

  logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b01};

  dmem_port_sched dut (
    .i_clk           (clk),
    .i_reset_n       (reset_n),
    .i_flush         (flush),
    .i_st_valid      (st_valid),
    .o_st_ready      (st_ready),
    .i_st_addr       (st_addr),
    .i_st_data       (st_data),
    .i_ld_valid      (ld_valid),
    .o_ld_ready      (ld_ready),
    .i_ld_addr       (ld_addr),
    .i_ld_tag        (ld_tag),
    .o_ld_resp_valid (resp_valid),
    .i_ld_resp_ready (resp_ready),
    .o_ld_resp_tag   (resp_tag),
    .o_ld_resp_data  (resp_data),
    .o_mem_addr      (mem_addr),
    .o_mem_wr_data   (mem_wr_data),
    .o_mem_write     (mem_write),
    .o_mem_read      (mem_read),
    .i_mem_rd_data   (mem_rd_data),
    .o_busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign ma = mem_addr[4:0];

  always @(posedge clk) begin
    if (mem_write) begin
      for (int k = 0; k < 4; k++) mem[ma + 5'(k)] <= mem_wr_data[8*k +: 8];
    end
    if (mem_read) mem_rd_data <= {mem[ma + 5'd3], mem[ma + 5'd2], mem[ma + 5'd1], mem[ma]};
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; flush = 1'b0; st_valid = 1'b1; st_addr = 32'h4; st_data = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_tag = '0; resp_ready = 1'b1;
    step(); step();
    chk("rst_st_ready", 64'(st_ready), 64'd0);
    chk("rst_ld_ready", 64'(ld_ready), 64'd0);
    chk("rst_resp_v", 64'(resp_valid), 64'd0);
    chk("rst_mem_wr", 64'(mem_write), 64'd0);
    chk("rst_mem_rd", 64'(mem_read), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_resp_data", 64'(resp_data), 64'd0);
    st_valid = 1'b0; reset_n = 1'b1;
    step();

    // store then dependent load
    st_valid = 1'b1; st_addr = 32'h04; st_data = 32'hDEADBEEF; #1;
    chk("st_ready", 64'(st_ready), 64'd1);
    step();
    st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 32'h04; ld_tag = 4'd3; #1;
    chk("wr_mem_write", 64'(mem_write), 64'd1);
    chk("wr_mem_addr", 64'(mem_addr), 64'h4);
    chk("wr_mem_data", 64'(mem_wr_data), 64'hDEADBEEF);
    chk("ld_ready", 64'(ld_ready), 64'd1);
    step();
    ld_valid = 1'b0; #1;
    chk("rd_mem_read", 64'(mem_read), 64'd1);
    chk("rd_mem_write", 64'(mem_write), 64'd0);
    step();
    chk("lat_resp_v2", 64'(resp_valid), 64'd0);
    chk("lat_busy", 64'(busy), 64'd1);
    step();
    chk("lat_resp_v3", 64'(resp_valid), 64'd1);
    chk("lat_resp_tag", 64'(resp_tag), 64'd3);
    chk("lat_resp_data", 64'(resp_data), 64'hDEADBEEF);
    step();
    chk("pop_resp_v", 64'(resp_valid), 64'd0);
    chk("pop_busy", 64'(busy), 64'd0);

    // both requesters held high from reset
    reset_n = 1'b0; step(); reset_n = 1'b1;
    st_valid = 1'b1; st_addr = 32'h08; st_data = 32'hA5A5A5A5;
    ld_valid = 1'b1; ld_addr = 32'h04; ld_tag = 4'd1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("arb_grant", 64'({ld_ready, st_ready}), 64'(exp_g[c]));
      chk("arb_excl", 64'(mem_write & mem_read), 64'd0);
      step();
    end
    st_valid = 1'b0; ld_valid = 1'b0; #1;
    chk("arb_resp_v", 64'(resp_valid), 64'd1);
    chk("arb_resp_tag", 64'(resp_tag), 64'd1);
    chk("arb_resp_data", 64'(resp_data), 64'hDEADBEEF);
    step();

    // response backpressure
    resp_ready = 1'b0; ld_valid = 1'b1; ld_addr = 32'h08; ld_tag = 4'd5; #1;
    chk("bp_ld_ready", 64'(ld_ready), 64'd1);
    step();
    ld_addr = 32'h04; ld_tag = 4'd6;
    for (int c = 0; c < 2; c++) begin
      #1; chk("bp_blocked", 64'(ld_ready), 64'd0); step();
    end
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_hold_v", 64'(resp_valid), 64'd1);
      chk("bp_hold_tag", 64'(resp_tag), 64'd5);
      chk("bp_hold_data", 64'(resp_data), 64'hA5A5A5A5);
      chk("bp_hold_ldr", 64'(ld_ready), 64'd0);
      step();
    end
    resp_ready = 1'b1; #1;
    chk("bp_pop_ldr", 64'(ld_ready), 64'd1);
    step();
    ld_valid = 1'b0; #1;
    chk("bp_after_pop", 64'(resp_valid), 64'd0);
    step(); step();
    chk("bp2_resp_tag", 64'(resp_tag), 64'd6);
    chk("bp2_resp_data", 64'(resp_data), 64'hDEADBEEF);
    step();

    // flush one cycle after a load accept, store accepted during flush
    ld_valid = 1'b1; ld_addr = 32'h04; ld_tag = 4'd7; #1;
    chk("fl_ld_acc", 64'(ld_ready), 64'd1);
    step();
    ld_addr = 32'h08; ld_tag = 4'd8; flush = 1'b1;
    st_valid = 1'b1; st_addr = 32'h10; st_data = 32'h55667788; #1;
    chk("fl_ld_ready", 64'(ld_ready), 64'd0);
    chk("fl_st_ready", 64'(st_ready), 64'd1);
    chk("fl_mem_read", 64'(mem_read), 64'd1);
    step();
    flush = 1'b0; st_valid = 1'b0; #1;
    chk("fl_after_ldr", 64'(ld_ready), 64'd1);
    chk("fl_resp_v", 64'(resp_valid), 64'd0);
    chk("fl_st_write", 64'(mem_write), 64'd1);
    step();
    ld_valid = 1'b0; #1;
    chk("fl_no_tag7", 64'(resp_valid), 64'd0);
    step();
    chk("fl_no_tag7b", 64'(resp_valid), 64'd0);
    step();
    chk("fl_tag8_v", 64'(resp_valid), 64'd1);
    chk("fl_tag8_tag", 64'(resp_tag), 64'd8);
    chk("fl_tag8_data", 64'(resp_data), 64'hA5A5A5A5);
    step();

    // upper address bits pass through and are ignored by memory
    ld_valid = 1'b1; ld_addr = 32'hABCD_0110; ld_tag = 4'd4; #1;
    chk("hi_ld_ready", 64'(ld_ready), 64'd1);
    step();
    ld_valid = 1'b0; #1;
    chk("hi_mem_addr", 64'(mem_addr), 64'hABCD0110);
    step(); step();
    chk("hi_resp_data", 64'(resp_data), 64'h55667788);
    chk("hi_resp_tag", 64'(resp_tag), 64'd4);
    step();

    // word store wrapping past the top of memory
    st_valid = 1'b1; st_addr = 32'h1E; st_data = 32'h11223344; #1;
    chk("wrap_st_ready", 64'(st_ready), 64'd1);
    step();
    st_valid = 1'b0;
    step();
    chk("wrap_b1e", 64'(mem[30]), 64'h44);
    chk("wrap_b1f", 64'(mem[31]), 64'h33);
    chk("wrap_b00", 64'(mem[0]), 64'h22);
    chk("wrap_b01", 64'(mem[1]), 64'h11);
    ld_valid = 1'b1; ld_addr = 32'h1E; ld_tag = 4'd2; #1;
    chk("wrap_ld_ready", 64'(ld_ready), 64'd1);
    step();
    ld_valid = 1'b0;
    step(); step();
    chk("wrap_resp_data", 64'(resp_data), 64'h11223344);
    chk("wrap_resp_tag", 64'(resp_tag), 64'd2);
    step();

    // reset while a load sits in the read-wait stage
    ld_valid = 1'b1; ld_addr = 32'h04; ld_tag = 4'd9;
    step();
    ld_valid = 1'b0;
    step();
    chk("mid_busy", 64'(busy), 64'd1);
    reset_n = 1'b0; #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_resp", 64'(resp_valid), 64'd0);
    chk("mid_rst_rd", 64'(mem_read), 64'd0);
    chk("mid_rst_addr", 64'(mem_addr), 64'd0);
    chk("mid_rst_tag", 64'(resp_tag), 64'd0);
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1; chk("mid_no_stale", 64'(resp_valid), 64'd0); step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
